// File: rtl/alu_result_fifo.sv
// First-word fall-through FIFO for ALU result words and their flags, with a
// saturating count of accepted entries that carried the overflow flag.
module alu_result_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [31:0]              in_result,
  input  logic                     in_carryout,
  input  logic                     in_zero,
  input  logic                     in_overflow,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [31:0]              out_result,
  output logic                     out_carryout,
  output logic                     out_zero,
  output logic                     out_overflow,
  output logic [$clog2(DEPTH):0]   count,
  output logic [7:0]               ovf_events,
  input  logic                     clr_events
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = 35;

  logic [EW-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [CW-1:0] r_count;
  logic [7:0]    r_ovf;

  logic          w_wr;
  logic          w_rd;
  logic [EW-1:0] w_head;

  // Handshakes depend only on registered occupancy, so a full FIFO never
  // accepts a word even when the head is being read in the same cycle.
  assign in_ready  = (r_count < CW'(DEPTH));
  assign out_valid = (r_count != {CW{1'b0}});
  assign w_wr      = in_valid && in_ready;
  assign w_rd      = out_valid && out_ready;

  assign count      = r_count;
  assign ovf_events = r_ovf;

  // Head entry is presented only while occupied; otherwise the outputs are zero.
  always_comb begin
    w_head = {EW{1'b0}};
    if (out_valid) begin
      w_head = r_mem[r_rptr];
    end else begin
      w_head = {EW{1'b0}};
    end
  end

  assign {out_result, out_carryout, out_zero, out_overflow} = w_head;

  // Storage array: no reset, contents are hidden whenever count is zero.
  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_mem[r_wptr] <= {in_result, in_carryout, in_zero, in_overflow};
    end
  end

  // Pointers and occupancy; pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= {AW{1'b0}};
      r_rptr  <= {AW{1'b0}};
      r_count <= {CW{1'b0}};
    end else begin
      if (w_wr) begin
        r_wptr <= r_wptr + AW'(1);
      end
      if (w_rd) begin
        r_rptr <= r_rptr + AW'(1);
      end
      case ({w_wr, w_rd})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Overflow-event counter; clear wins over a same-cycle increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ovf <= 8'd0;
    end else if (clr_events) begin
      r_ovf <= 8'd0;
    end else if (w_wr && in_overflow && (r_ovf != 8'hFF)) begin
      r_ovf <= r_ovf + 8'd1;
    end else begin
      r_ovf <= r_ovf;
    end
  end

endmodule

// File: tb/tb_alu_result_fifo.sv
// Self-checking bench for alu_result_fifo: queue-based reference model checked
// every cycle, directed scenarios with literal expectations, then random traffic.
module tb_alu_result_fifo;

  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [31:0]   in_result;
  logic          in_carryout;
  logic          in_zero;
  logic          in_overflow;
  logic          out_valid;
  logic          out_ready;
  logic [31:0]   out_result;
  logic          out_carryout;
  logic          out_zero;
  logic          out_overflow;
  logic [CW-1:0] count;
  logic [7:0]    ovf_events;
  logic          clr_events;

  int checks = 0;
  int errors = 0;

  logic [34:0] mq[$];
  int          m_ovf = 0;

  alu_result_fifo #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_result(in_result), .in_carryout(in_carryout),
    .in_zero(in_zero), .in_overflow(in_overflow),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_carryout(out_carryout),
    .out_zero(out_zero), .out_overflow(out_overflow),
    .count(count), .ovf_events(ovf_events), .clr_events(clr_events)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a plain queue of accepted tuples and an integer event count.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      m_ovf <= 0;
    end else begin
      automatic bit wr = in_valid && (mq.size() < DEPTH);
      automatic bit rd = out_ready && (mq.size() > 0);
      if (rd) void'(mq.pop_front());
      if (wr) mq.push_back({in_result, in_carryout, in_zero, in_overflow});
      if (clr_events) m_ovf <= 0;
      else if (wr && in_overflow && m_ovf < 255) m_ovf <= m_ovf + 1;
      else m_ovf <= m_ovf;
    end
  end

  // Per-cycle comparison against the model, sampled mid-cycle.
  always @(negedge clk) begin
    if (rst_n) begin
      automatic logic [34:0] exp_head = (mq.size() > 0) ? mq[0] : 35'd0;
      check("in_ready",  64'(in_ready),  64'(mq.size() < DEPTH));
      check("out_valid", 64'(out_valid), 64'(mq.size() != 0));
      check("count",     64'(count),     64'(mq.size()));
      check("head",      64'({out_result, out_carryout, out_zero, out_overflow}), 64'(exp_head));
      check("ovf_events", 64'(ovf_events), 64'(m_ovf));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] d, input logic c, input logic z,
                       input logic o, input logic rdy);
    in_valid    = v;
    in_result   = d;
    in_carryout = c;
    in_zero     = z;
    in_overflow = o;
    out_ready   = rdy;
  endtask

  initial begin
    logic [31:0] vals [4];
    rst_n = 1'b0;
    clr_events = 1'b0;
    drive(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    #2;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_count", 64'(count), 64'd0);
    check("rst_ovf", 64'(ovf_events), 64'd0);
    step();
    rst_n = 1'b1;
    step();

    // Basic ordering
    drive(1'b1, 32'h00000005, 1'b0, 1'b0, 1'b0, 1'b0); step();
    drive(1'b1, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b0, 1'b0); step();
    drive(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("ord_count", 64'(count), 64'd2);
    check("ord_head0", 64'(out_result), 64'h5);
    out_ready = 1'b1; step();
    check("ord_head1", 64'(out_result), 64'hFFFFFFFF);
    check("ord_c1", 64'(out_carryout), 64'd1);
    step();
    check("ord_empty_valid", 64'(out_valid), 64'd0);
    check("ord_empty_data", 64'(out_result), 64'd0);
    out_ready = 1'b0;

    // Full
    vals[0] = 32'h11111111; vals[1] = 32'h22222222; vals[2] = 32'h33333333; vals[3] = 32'h44444444;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, vals[i], 1'b0, 1'b0, 1'b0, 1'b0); step();
    end
    check("full_in_ready", 64'(in_ready), 64'd0);
    check("full_count", 64'(count), 64'd4);
    drive(1'b1, 32'hDEADBEEF, 1'b0, 1'b0, 1'b0, 1'b0); step();
    check("full_drop_count", 64'(count), 64'd4);
    drive(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      check("full_drain", 64'(out_result), 64'(vals[i]));
      step();
    end
    check("full_drained", 64'(out_valid), 64'd0);

    // Simultaneous write and read at count=2
    drive(1'b1, 32'd100, 1'b0, 1'b0, 1'b0, 1'b0); step();
    drive(1'b1, 32'd101, 1'b0, 1'b0, 1'b0, 1'b0); step();
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 32'd102 + 32'(i), 1'b0, 1'b0, 1'b0, 1'b1);
      check("sim_head", 64'(out_result), 64'(100 + i));
      step();
      check("sim_count", 64'(count), 64'd2);
    end
    drive(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("sim_tail0", 64'(out_result), 64'd110);
    step();
    check("sim_tail1", 64'(out_result), 64'd111);
    step();

    // Overflow event counter saturation and clear priority
    for (int i = 0; i < 260; i++) begin
      drive(1'b1, 32'(i), 1'b0, 1'b0, 1'b1, 1'b1); step();
    end
    check("ovf_sat", 64'(ovf_events), 64'd255);
    clr_events = 1'b1;
    step();
    clr_events = 1'b0;
    check("ovf_clr", 64'(ovf_events), 64'd0);
    drive(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1); step(); step();

    // Asynchronous reset mid-transfer
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'h700 + 32'(i), 1'b0, 1'b0, 1'b0, 1'b0); step();
    end
    drive(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("ar_count3", 64'(count), 64'd3);
    #2 rst_n = 1'b0;
    #1;
    check("ar_out_valid", 64'(out_valid), 64'd0);
    check("ar_count", 64'(count), 64'd0);
    check("ar_in_ready", 64'(in_ready), 64'd1);
    check("ar_data", 64'(out_result), 64'd0);
    rst_n = 1'b1;
    step();
    drive(1'b1, 32'h0000ABCD, 1'b0, 1'b1, 1'b0, 1'b0); step();
    drive(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("ar_head", 64'(out_result), 64'hABCD);
    check("ar_head_count", 64'(count), 64'd1);
    out_ready = 1'b1; step(); out_ready = 1'b0;

    // Empty read has no effect
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("er_count", 64'(count), 64'd0);
      check("er_valid", 64'(out_valid), 64'd0);
    end
    drive(1'b1, 32'h12345678, 1'b0, 1'b0, 1'b1, 1'b0); step();
    drive(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("er_head", 64'({out_result, out_overflow}), 64'({32'h12345678, 1'b1}));
    out_ready = 1'b1; step();
    check("er_drained", 64'(out_valid), 64'd0);

    // Random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      drive(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      clr_events = ($urandom_range(0, 31) == 0);
      step();
    end
    drive(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    clr_events = 1'b0;
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
